// File: rtl/gate_matrix_reader_if.sv
// rtl/gate_matrix_reader_if.sv - valid/ready word stream from the gate-matrix reader to the datapath
interface gate_matrix_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = 4
);
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic [IDX_W-1:0]      m_index;
    logic                  m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_index,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_index,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/gate_matrix_reader.sv
// rtl/gate_matrix_reader.sv - fetches one COUNT-word gate-matrix block from RAM onto a valid/ready stream
module gate_matrix_reader #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12,
    parameter int COUNT         = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] base_addr,
    output logic                     busy,
    output logic                     done,
    output logic                     ram_req,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0]    ram_data,
    gate_matrix_reader_if.master     m
);
    localparam int IDX_W = $clog2(COUNT);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        LOAD,
        SEND
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;

    // ram_addr itself holds base+idx; it wraps naturally at 2^ADDRESS_WIDTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ram_req   <= 1'b0;
            ram_addr  <= '0;
            m.m_valid <= 1'b0;
            m.m_data  <= '0;
            m.m_index <= '0;
            m.m_last  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ram_addr <= base_addr;
                        idx      <= '0;
                        busy     <= 1'b1;
                        ram_req  <= 1'b1;
                        state    <= ADDR;
                    end
                end
                ADDR: begin
                    state <= LOAD;
                end
                LOAD: begin
                    m.m_data  <= ram_data;
                    m.m_index <= idx;
                    m.m_last  <= (idx == IDX_W'(COUNT - 1));
                    m.m_valid <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (m.m_ready) begin
                        m.m_valid <= 1'b0;
                        if (m.m_last) begin
                            m.m_last <= 1'b0;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            ram_req  <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            idx      <= idx + IDX_W'(1);
                            ram_addr <= ram_addr + ADDRESS_WIDTH'(1);
                            state    <= ADDR;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gate_matrix_reader.sv
// tb/tb_gate_matrix_reader.sv - directed self-checking bench for gate_matrix_reader
module tb_gate_matrix_reader;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] base_addr;
    logic        busy, done, ram_req;
    logic [11:0] ram_addr;
    logic [31:0] ram_data;

    logic [31:0] mem [4096];
    logic [31:0] expv [16];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    gate_matrix_reader_if #(.DATA_WIDTH(32), .IDX_W(4)) s_if ();

    gate_matrix_reader #(.DATA_WIDTH(32), .ADDRESS_WIDTH(12), .COUNT(16)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .busy(busy), .done(done), .ram_req(ram_req), .ram_addr(ram_addr),
        .ram_data(ram_data), .m(s_if.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) ram_data <= mem[ram_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 16; i++) expv[i] = 32'h0;
    endtask

    task automatic exp_pauli_x();
        clear_exp();
        expv[2] = 32'h00001000; expv[7] = 32'h00001000;
        expv[8] = 32'h00001000; expv[13] = 32'h00001000;
    endtask

    // pre: start already driven high by the caller in the current cycle
    task automatic fetch(input logic [11:0] base, input int stall_at, input int stall_len,
                         input int done_ofs, input bit pre, input int ign_at, input int chain);
        int t0, tmo;
        logic [31:0] held;
        logic [11:0] ea;
        if (!pre) begin
            @(negedge clk);
            base_addr = base;
            start = 1'b1;
        end
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        check("busy_t1", {31'b0, busy}, 32'd1);
        check("ramreq_t1", {31'b0, ram_req}, 32'd1);
        check("addr_t1", {20'b0, ram_addr}, {20'b0, base});
        check("done_t1", {31'b0, done}, 32'd0);
        for (int k = 0; k < 16; k++) begin
            tmo = 0;
            while (!s_if.m_valid && tmo < 10) begin
                @(negedge clk);
                tmo++;
            end
            check("valid", {31'b0, s_if.m_valid}, 32'd1);
            if (k == 0) check("first_valid_cyc", 32'(cyc), 32'(t0 + 3));
            ea = base + 12'(k);
            check("data", s_if.m_data, expv[k]);
            check("index", {28'b0, s_if.m_index}, 32'(k));
            check("last", {31'b0, s_if.m_last}, {31'b0, k == 15});
            check("ram_addr", {20'b0, ram_addr}, {20'b0, ea});
            if (k == ign_at) begin
                base_addr = 12'd1100;
                start = 1'b1;
            end
            if (k == stall_at) begin
                s_if.m_ready = 1'b0;
                held = s_if.m_data;
                repeat (stall_len) begin
                    @(negedge clk);
                    start = 1'b0;
                    check("stall_valid", {31'b0, s_if.m_valid}, 32'd1);
                    check("stall_data", s_if.m_data, held);
                    check("stall_index", {28'b0, s_if.m_index}, 32'(k));
                end
                s_if.m_ready = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
        end
        check("done_cyc", {31'b0, done}, 32'd1);
        check("done_time", 32'(cyc), 32'(t0 + done_ofs));
        check("busy_end", {31'b0, busy}, 32'd0);
        check("valid_end", {31'b0, s_if.m_valid}, 32'd0);
        if (chain >= 0) begin
            base_addr = 12'(chain);
            start = 1'b1;
        end else begin
            @(negedge clk);
            check("done_pulse_width", {31'b0, done}, 32'd0);
        end
    endtask

    initial begin
        int tmo;
        reset = 1'b1;
        start = 1'b0;
        base_addr = '0;
        s_if.m_ready = 1'b1;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[1002] = 32'h1000; mem[1007] = 32'h1000; mem[1008] = 32'h1000; mem[1013] = 32'h1000;
        mem[1200] = 32'h1000; mem[1205] = 32'h1000; mem[1210] = 32'hFFFFF000; mem[1215] = 32'hFFFFF000;
        mem[1300] = 32'hB50; mem[1302] = 32'hB50; mem[1305] = 32'hB50; mem[1307] = 32'hB50;
        mem[1308] = 32'hB50; mem[1313] = 32'hB50; mem[1310] = 32'hFFFFF4B0; mem[1315] = 32'hFFFFF4B0;
        for (int i = 0; i < 16; i++) mem[i] = 32'(i);
        for (int i = 4080; i < 4096; i++) mem[i] = 32'(i);

        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_ramreq", {31'b0, ram_req}, 32'd0);
        check("rst_valid", {31'b0, s_if.m_valid}, 32'd0);
        check("rst_last", {31'b0, s_if.m_last}, 32'd0);
        check("rst_addr", {20'b0, ram_addr}, 32'd0);
        check("rst_data", s_if.m_data, 32'd0);
        check("rst_index", {28'b0, s_if.m_index}, 32'd0);
        reset = 1'b0;

        exp_pauli_x();
        fetch(12'd1000, -1, 0, 49, 1'b0, -1, -1);

        clear_exp();
        expv[0] = 32'hB50; expv[2] = 32'hB50; expv[5] = 32'hB50; expv[7] = 32'hB50;
        expv[8] = 32'hB50; expv[13] = 32'hB50; expv[10] = 32'hFFFFF4B0; expv[15] = 32'hFFFFF4B0;
        fetch(12'd1300, -1, 0, 49, 1'b0, -1, -1);

        exp_pauli_x();
        fetch(12'd1000, 3, 5, 54, 1'b0, -1, -1);

        for (int i = 0; i < 6; i++) expv[i] = 32'(4090 + i);
        for (int i = 6; i < 16; i++) expv[i] = 32'(i - 6);
        fetch(12'd4090, -1, 0, 49, 1'b0, -1, -1);

        exp_pauli_x();
        fetch(12'd1000, -1, 0, 49, 1'b0, 4, 1200);
        clear_exp();
        expv[0] = 32'h1000; expv[5] = 32'h1000; expv[10] = 32'hFFFFF000; expv[15] = 32'hFFFFF000;
        fetch(12'd1200, -1, 0, 49, 1'b1, -1, -1);

        @(negedge clk);
        base_addr = 12'd1000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tmo = 0;
        while (!(s_if.m_valid && s_if.m_index == 4'd5) && tmo < 40) begin
            @(negedge clk);
            tmo++;
        end
        check("reach_idx5", {28'b0, s_if.m_index}, 32'd5);
        reset = 1'b1;
        #1;
        check("abort_valid", {31'b0, s_if.m_valid}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_ramreq", {31'b0, ram_req}, 32'd0);
        check("abort_addr", {20'b0, ram_addr}, 32'd0);
        check("abort_data", s_if.m_data, 32'd0);
        check("abort_index", {28'b0, s_if.m_index}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", {31'b0, done}, 32'd0);
            check("abort_no_valid", {31'b0, s_if.m_valid}, 32'd0);
        end
        exp_pauli_x();
        fetch(12'd1000, -1, 0, 49, 1'b0, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/gate_matrix_reader.md
# gate_matrix_reader

Bus-initiator block that fetches one gate-matrix block of COUNT consecutive words from the single-port data RAM and presents them, in address order, on a valid/ready stream to the matrix-arithmetic datapath. It drives the RAM address (the top level muxes it onto the RAM when `ram_req` is high) and consumes the RAM's registered read data. The block is a pure reader: words are Q12 fixed point (4096 = 1.0, two's complement) and pass through unmodified.

## Interface
- `DATA_WIDTH`, 32, word width
- `ADDRESS_WIDTH`, 12, RAM address width
- `COUNT`, 16, words per block (power of two, ≥2); `IDX_W` = log2(COUNT)

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  request a block fetch; sampled only in IDLE
- `base_addr`  in  ADDRESS_WIDTH  first RAM address of the block; latched on accepted `start`
- `busy`  out  1  high from the cycle after accepted `start` until the last handshake
- `done`  out  1  one-cycle pulse after the last word's handshake
- `ram_req`  out  1  high while the block owns the RAM address port (RAM `wEn` must be 0 then)
- `ram_addr`  out  ADDRESS_WIDTH  RAM address
- `ram_data`  in  DATA_WIDTH  RAM registered read data (valid one cycle after address)
- `m_valid`  out  1  stream word valid
- `m_ready`  in  1  downstream accepts word
- `m_data`  out  DATA_WIDTH  word
- `m_index`  out  IDX_W  word index within block, 0..COUNT-1
- `m_last`  out  1  high with index COUNT-1

## Operation
- States: IDLE, ADDR, LOAD, SEND.
- IDLE: `start`=1 → latch `base_addr`, idx←0, go ADDR. Otherwise stay.
- ADDR: `ram_addr` = base+idx; RAM captures it at this cycle's edge. Go LOAD.
- LOAD: `ram_data` now holds word idx; register it into `m_data`, `m_index`←idx, `m_last`←(idx==COUNT-1); go SEND.
- SEND: `m_valid`=1. On `m_valid & m_ready`: if `m_last`, go IDLE and pulse `done`; else idx←idx+1, go ADDR. While `m_ready`=0, `m_data`/`m_index`/`m_last` held stable.
- `ram_req` = 1 in ADDR, LOAD, SEND; `ram_addr` held at base+idx for all three.
- Address arithmetic modulo 2^ADDRESS_WIDTH: base 4090, COUNT 16 reads 4090..4095 then 0..9.
- `start` while not IDLE is ignored (no queueing, no re-latch of `base_addr`).
- `m_ready` outside SEND has no effect.

## Timing
- Reset (async assert, sync release): state IDLE; `busy`, `done`, `ram_req`, `m_valid`, `m_last` = 0; `ram_addr`, `m_data`, `m_index` = 0.
- Reset mid-block: immediate abort; no `done`, no further `m_valid`; next `start` after release begins a fresh block.
- `start` at cycle T: ADDR at T+1, LOAD at T+2, `m_valid` first high at T+3.
- With `m_ready` tied high: 3 cycles per word; COUNT=16 → last handshake at T+48, `done` high at T+49 only.
- `done` and `busy`=0 coincide in the first IDLE cycle; `start` in that same cycle is accepted (back-to-back blocks, ADDR the next cycle).
- `busy` = (state ≠ IDLE); `done` registered, exactly one cycle wide.
- Each stall cycle (`m_ready`=0 in SEND) adds exactly one cycle; no word dropped or duplicated.

## Test plan
- RAM preloaded with Pauli-X block; `start`, `base_addr`=1000, `m_ready`=1 → 16 words, index 2, 7, 8, 13 = 4096 (0x00001000), others 0; `m_last` only on index 15; `done` at T+49.
- Hadamard block, `base_addr`=1300 → index 0,2,5,7,8,13 = 2896 (0x00000B50); index 10,15 = 0xFFFFF4B0; others 0.
- Same fetch with `m_ready` low for 5 cycles at index 3 → `m_data`/`m_index` stable during stall, `done` at T+54, sequence intact.
- `base_addr`=4090 with RAM[i]=i → `m_data` 4090..4095, 0..9; `ram_addr` wraps to 0 without error.
- `start` pulsed with `base_addr`=1100 while block at 1000 in progress → ignored, all 16 words from 1000; then `start` on `done` cycle with 1200 → Pauli-Z block (index 0,5 = 4096; 10,15 = 0xFFFFF000) begins next cycle.
- `reset` asserted during SEND of index 5 → all outputs 0 same cycle, no `done`; new fetch after release returns index 0 first.
